game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_controller.sv | 135 +++++++++++++
 tb/tb_game_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// game_controller: tic-tac-toe referee; define GAME_CONTROLLER_MOVE_TIMEOUT_EN to add a per-turn move timeout
module game_controller #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  output logic [1:0] pos1,
  output logic [1:0] pos2,
  output logic [1:0] pos3,
  output logic [1:0] pos4,
  output logic [1:0] pos5,
  output logic [1:0] pos6,
  output logic [1:0] pos7,
  output logic [1:0] pos8,
  output logic [1:0] pos9,
  output logic [1:0] turn,
  output logic       illegal,
  output logic       game_over,
  output logic       win,
  output logic [1:0] who,
  output logic       draw,
  output logic [3:0] wins_x,
  output logic [3:0] wins_o
);
  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;
  state_t state;
  logic [15:0][1:0] b;
  logic [3:0] move_count;
  logic [1:0] l [8];
  logic [1:0] line_who;
  logic [1:0] score;
  logic legal;
  logic accept;
  logic timeout;

  function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] c, input logic [1:0] d);
    return (a != 2'b00 && a == c && a == d) ? a : 2'b00;
  endfunction

  assign {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1} = {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]};
  assign move_ready = state == PLAY;
  assign game_over = state == DONE;
  assign legal = move_pos != 4'd0 && move_pos <= 4'd9 && b[move_pos] == 2'b00;
  assign accept = state == PLAY && move_valid && legal;
  assign l[0] = line3(b[1], b[2], b[3]);
  assign l[1] = line3(b[4], b[5], b[6]);
  assign l[2] = line3(b[7], b[8], b[9]);
  assign l[3] = line3(b[1], b[4], b[7]);
  assign l[4] = line3(b[2], b[5], b[8]);
  assign l[5] = line3(b[3], b[6], b[9]);
  assign l[6] = line3(b[1], b[5], b[9]);
  assign l[7] = line3(b[3], b[5], b[7]);

  // any completed line names the winner; only the last mover can own one
  always_comb begin
    line_who = 2'b00;
    for (int i = 0; i < 8; i++) line_who = (l[i] != 2'b00) ? l[i] : line_who;
  end

`ifdef GAME_CONTROLLER_MOVE_TIMEOUT_EN
  logic [31:0] cnt;
  assign timeout = state == PLAY && !accept && cnt == 32'(TIMEOUT_CYCLES - 1);

  // idle cycles of the current turn; restarts whenever the turn is not waiting
  always_ff @(posedge clk) begin
    if (!reset_n || new_game || state != PLAY || accept) cnt <= '0;
    else cnt <= cnt + 32'd1;
  end
`else
  assign timeout = 1'b0 && TIMEOUT_CYCLES > 0;
`endif

  // player credited with a win on this edge, 00 when nobody scores
  assign score = new_game ? 2'b00 : state == CHECK ? line_who : timeout ? ~turn : 2'b00;

  // saturating win tallies, survive new_game
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wins_x <= '0;
      wins_o <= '0;
    end else begin
      if (score == 2'b01 && wins_x != 4'hf) wins_x <= wins_x + 4'd1;
      if (score == 2'b10 && wins_o != 4'hf) wins_o <= wins_o + 4'd1;
    end
  end

  // game FSM: board, turn and result registers
  always_ff @(posedge clk) begin
    if (!reset_n || new_game) begin
      state <= PLAY;
      b <= '0;
      move_count <= '0;
      turn <= FIRST_PLAYER;
      win <= 1'b0;
      who <= 2'b00;
      draw <= 1'b0;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        PLAY:
          if (accept) begin
            b[move_pos] <= turn;
            move_count <= move_count + 4'd1;
            state <= CHECK;
          end else if (timeout) begin
            state <= DONE;
            win <= 1'b1;
            who <= score;
            turn <= 2'b00;
          end else if (move_valid) illegal <= 1'b1;
        CHECK:
          if (score != 2'b00) begin
            state <= DONE;
            win <= 1'b1;
            who <= score;
            turn <= 2'b00;
          end else if (move_count == 4'd9) begin
            state <= DONE;
            draw <= 1'b1;
            turn <= 2'b00;
          end else begin
            state <= PLAY;
            turn <= ~turn;
          end
        default: state <= DONE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: randomized scoreboard bench for game_controller
module tb_game_controller;
`ifdef GAME_CONTROLLER_MOVE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1000;
`endif
  localparam int ILL = 0, TURN = 1, FIN = 2;
  logic clk = 1'b0, reset_n = 1'b0, new_game = 1'b0, move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic move_ready, illegal, game_over, win, draw;
  logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9, turn, who;
  logic [3:0] wins_x, wins_o;
  wire [17:0] dbd = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  game_controller #(.FIRST_PLAYER(2'b01), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .new_game(new_game), .move_valid(move_valid), .move_pos(move_pos),
    .move_ready(move_ready), .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
    .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9), .turn(turn), .illegal(illegal),
    .game_over(game_over), .win(win), .who(who), .draw(draw), .wins_x(wins_x), .wins_o(wins_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    logic [17:0] bd;
    logic [1:0] turn;
    logic win;
    logic [1:0] who;
    logic draw;
    logic [3:0] wx;
    logic [3:0] wo;
  } exp_t;
  exp_t q[$];
  int ncmp = 0, nbad = 0;
  int bd[10];
  int cur = 1, mc = 0, wx = 0, wo = 0;
  bit done = 0;
  bit pgo = 0, pmr = 1;

  function automatic logic [17:0] pk();
    logic [17:0] r = '0;
    for (int i = 1; i <= 9; i++) r[2*(i-1) +: 2] = bd[i][1:0];
    return r;
  endfunction

  function automatic int winner();
    int ln[8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7}, '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
    for (int i = 0; i < 8; i++)
      if (bd[ln[i][0]] != 0 && bd[ln[i][0]] == bd[ln[i][1]] && bd[ln[i][0]] == bd[ln[i][2]]) return bd[ln[i][0]];
    return 0;
  endfunction

  task automatic push(input int kind, input int w);
    exp_t e;
    e.kind = kind;
    e.bd = pk();
    e.turn = (kind == FIN) ? 2'd0 : cur[1:0];
    e.win = w != 0;
    e.who = w[1:0];
    e.draw = kind == FIN && w == 0;
    e.wx = wx[3:0];
    e.wo = wo[3:0];
    q.push_back(e);
  endtask

  task automatic chk(input string n, input int a, input int e);
    ncmp++;
    if (a != e) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic check(input int k);
    exp_t e;
    bit ok;
    ncmp++;
    if (q.size() == 0) begin
      nbad++;
      $display("FAIL unexpected_event kind=%0d board=%h turn=%0d", k, dbd, turn);
    end else begin
      e = q.pop_front();
      ok = e.kind == k && dbd == e.bd && turn == e.turn && win == e.win && who == e.who && draw == e.draw;
      if (k == FIN) ok = ok && wins_x == e.wx && wins_o == e.wo;
      if (!ok) begin
        nbad++;
        $display("FAIL event_kind%0d: got kind=%0d board=%h turn=%0d win=%b who=%0d draw=%b wx=%0d wo=%0d expected kind=%0d board=%h turn=%0d win=%b who=%0d draw=%b wx=%0d wo=%0d",
                 k, k, dbd, turn, win, who, draw, wins_x, wins_o, e.kind, e.bd, e.turn, e.win, e.who, e.draw, e.wx, e.wo);
      end
    end
  endtask

  // monitor: every DUT event consumes one expected entry
  always @(negedge clk) begin
    if (illegal === 1'b1) check(ILL);
    if (game_over === 1'b1 && !pgo) check(FIN);
    if (move_ready === 1'b1 && !pmr) check(TURN);
    pgo = game_over === 1'b1;
    pmr = move_ready === 1'b1;
  end

  task automatic model_clear();
    for (int i = 0; i < 10; i++) bd[i] = 0;
    cur = 1;
    mc = 0;
    done = 0;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (move_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (move_ready !== 1'b1) chk("ready_timeout", 0, 1);
  endtask

  task automatic play(input int pos);
    bit ok;
    int w;
    wait_ready();
    move_valid = 1'b1;
    move_pos = pos[3:0];
    ok = pos >= 1 && pos <= 9 && bd[(pos >= 1 && pos <= 9) ? pos : 0] == 0;
    if (!ok) push(ILL, 0);
    else begin
      bd[pos] = cur;
      mc++;
      w = winner();
      if (w != 0) begin
        if (w == 1 && wx < 15) wx++;
        if (w == 2 && wo < 15) wo++;
        push(FIN, w);
        done = 1;
      end else if (mc == 9) begin
        push(FIN, 0);
        done = 1;
      end else begin
        cur = 3 - cur;
        push(TURN, 0);
      end
    end
    @(negedge clk);
    move_valid = 1'b0;
    if (ok) @(negedge clk);
  endtask

  task automatic newgame(input bit withmove);
    bit was_done = done;
    new_game = 1'b1;
    move_valid = withmove;
    move_pos = 4'd3;
    model_clear();
    if (was_done) push(TURN, 0);
    @(negedge clk);
    new_game = 1'b0;
    move_valid = 1'b0;
  endtask

  initial begin
    int em[$];
    int pos, steps;
    bit prev_ill;
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_ready", move_ready, 1);
    chk("rst_turn", turn, 1);
    chk("rst_game_over", game_over, 0);
    chk("rst_results", {win, who, draw, illegal}, 0);
    chk("rst_tallies", {wins_x, wins_o}, 0);
    chk("rst_board", dbd, 0);

    play(1); play(4); play(2); play(5); play(3);
    newgame(0);
    play(1); play(2); play(3); play(5); play(4); play(6); play(8); play(7); play(9);
    newgame(0);
    play(5); play(5); play(0);
    chk("ill_pos5", pos5, 1);
    chk("ill_turn", turn, 2);
    newgame(1);
    chk("ng_board", dbd, 0);
    chk("ng_turn", turn, 1);
    chk("ng_illegal", illegal, 0);
    chk("ng_pos3", pos3, 0);

`ifdef GAME_CONTROLLER_MOVE_TIMEOUT_EN
    wo++;
    push(FIN, 2);
    done = 1;
    for (int k = 0; k < 20 && game_over !== 1'b1; k++) @(negedge clk);
    chk("timeout_done", game_over, 1);
    newgame(0);
`else
    repeat (100) @(negedge clk);
    chk("idle_ready", move_ready, 1);
    chk("idle_game_over", game_over, 0);
    chk("idle_turn", turn, 1);
`endif

    play(1); play(4); play(2); play(5);
    move_valid = 1'b1;
    move_pos = 4'd3;
    @(negedge clk);
    move_valid = 1'b0;
    reset_n = 1'b0;
    model_clear();
    wx = 0;
    wo = 0;
    push(TURN, 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("midcheck_rst_wx", wins_x, 0);
    chk("midcheck_rst_over", game_over, 0);

    for (int g = 0; g < 17; g++) begin
      newgame(0);
      play(1); play(4); play(2); play(5); play(3);
    end
    chk("sat_wx", wins_x, 15);

    for (int g = 0; g < 40; g++) begin
      newgame(0);
      steps = 0;
      prev_ill = 0;
      while (!done && steps < 60) begin
        em.delete();
        for (int i = 1; i <= 9; i++) if (bd[i] == 0) em.push_back(i);
        if (!prev_ill && $urandom_range(0, 3) == 0) pos = $urandom_range(0, 15);
        else pos = em[$urandom_range(0, em.size() - 1)];
        prev_ill = !(pos >= 1 && pos <= 9 && bd[(pos >= 1 && pos <= 9) ? pos : 0] == 0);
        play(pos);
        steps++;
      end
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
